pe_sequencer: RTL and testbench

Control-side initiator for one fixed-point PE. It accepts a job descriptor and then streams operand pairs into the PE. It steers each product into the correct accumulator slot, so the PE's multiply and accumulate pipeline stays aligned. After the last accumulation it drains every used slot through the PE rounder and returns one rounded result per slot on a ready/valid stream.

---
 rtl/pe_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pe_sequencer
//  Brief    : Control-side initiator for one fixed-point PE. Accepts a job
//             descriptor, streams operand pairs into the PE while steering
//             each product to its accumulator slot, then drains every used
//             slot through the PE rounder onto a ready/valid result stream.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_sequencer #(
    parameter int DATA_W  = 16,
    parameter int NUM_ACC = 8,
    parameter int LEN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // job descriptor
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [LEN_W-1:0]           job_len,
    input  logic [$clog2(NUM_ACC)-1:0] job_slots,
    // operand stream
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [DATA_W-1:0]          op_a,
    input  logic [DATA_W-1:0]          op_b,
    // PE control
    output logic                       pe_clr_n,
    output logic [DATA_W-1:0]          pe_data_in_1,
    output logic [DATA_W-1:0]          pe_data_in_2,
    output logic [3:0]                 pe_add_number,
    output logic [3:0]                 pe_round_number,
    output logic                       pe_rounder_en,
    input  logic [DATA_W-1:0]          pe_data_out,
    // result stream
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_W-1:0]          res_data,
    output logic [$clog2(NUM_ACC)-1:0] res_slot,
    output logic                       res_last
);

    localparam int SLOT_W = $clog2(NUM_ACC);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_ROUND   = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_OUT     = 3'd6;

    logic [2:0]        state;
    logic [2:0]        state_next;

    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  step;
    logic [SLOT_W-1:0] slots;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] drain;
    logic [SLOT_W-1:0] drain_next;
    logic              flush_cnt;

    logic [SLOT_W-1:0] slot_p1;
    logic              vld_p1;

    logic              job_fire;
    logic              op_fire;
    logic              res_fire;
    logic              last_op;
    logic              last_drain;

    assign job_fire   = job_valid & job_ready;
    assign op_fire    = op_valid & op_ready;
    assign res_fire   = res_valid & res_ready;
    assign last_op    = (step == len) && (slot == slots);
    assign last_drain = (drain == slots);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (job_fire) state_next = S_CLEAR;
            S_CLEAR:   state_next = S_FEED;
            S_FEED:    if (op_fire && last_op) state_next = S_FLUSH;
            S_FLUSH:   if (flush_cnt) state_next = S_ROUND;
            S_ROUND:   state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_OUT;
            S_OUT: begin
                if (res_fire) state_next = last_drain ? S_IDLE : S_ROUND;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Handshake-side outputs decoded from the current state
    always_comb begin
        job_ready = (state == S_IDLE);
        op_ready  = (state == S_FEED);
        res_valid = (state == S_OUT);
    end

    // Next drain index, shared by the drain counter and the round-slot register
    always_comb begin
        drain_next = drain;
        if (job_fire) begin
            drain_next = '0;
        end else if (state == S_FLUSH && flush_cnt) begin
            drain_next = '0;
        end else if (res_fire && !last_drain) begin
            drain_next = drain + 1'b1;
        end
    end

    // Job descriptor latch and step/slot/flush/drain counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len       <= '0;
            slots     <= '0;
            step      <= '0;
            slot      <= '0;
            drain     <= '0;
            flush_cnt <= 1'b0;
        end else begin
            drain <= drain_next;
            if (job_fire) begin
                len       <= job_len;
                slots     <= job_slots;
                step      <= '0;
                slot      <= '0;
                flush_cnt <= 1'b0;
            end else if (op_fire) begin
                if (step == len) begin
                    step <= '0;
                    slot <= slot + 1'b1;
                end else begin
                    step <= step + 1'b1;
                end
            end
            if (state == S_FLUSH) begin
                flush_cnt <= ~flush_cnt;
            end
        end
    end

    // Operand path: accepted pair is forwarded, bubbles become zero so the PE adds 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_data_in_1 <= '0;
            pe_data_in_2 <= '0;
        end else begin
            pe_data_in_1 <= op_fire ? op_a : '0;
            pe_data_in_2 <= op_fire ? op_b : '0;
        end
    end

    // Slot pipeline: two stages so the slot lines up with the PE multiplier register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_p1       <= '0;
            vld_p1        <= 1'b0;
            pe_add_number <= '0;
        end else begin
            vld_p1 <= op_fire;
            if (op_fire) begin
                slot_p1 <= slot;
            end
            if (vld_p1) begin
                pe_add_number <= 4'(slot_p1);
            end
        end
    end

    // PE clear and rounder control, registered from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_clr_n        <= 1'b0;
            pe_rounder_en   <= 1'b0;
            pe_round_number <= '0;
        end else begin
            pe_clr_n      <= (state_next != S_CLEAR);
            pe_rounder_en <= (state_next == S_ROUND);
            if (state_next == S_ROUND) begin
                pe_round_number <= 4'(drain_next);
            end
        end
    end

    // Result capture from the PE rounder output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data <= '0;
            res_slot <= '0;
            res_last <= 1'b0;
        end else if (state == S_CAPTURE) begin
            res_data <= pe_data_out;
            res_slot <= drain;
            res_last <= last_drain;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_sequencer
//  Brief    : Self-checking bench for pe_sequencer with a behavioural PE and
//             a slot-sum reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pe_sequencer;

    localparam int DATA_W  = 16;
    localparam int NUM_ACC = 8;
    localparam int LEN_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [LEN_W-1:0]  job_len;
    logic [2:0]        job_slots;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              pe_clr_n;
    logic [DATA_W-1:0] pe_data_in_1;
    logic [DATA_W-1:0] pe_data_in_2;
    logic [3:0]        pe_add_number;
    logic [3:0]        pe_round_number;
    logic              pe_rounder_en;
    logic [DATA_W-1:0] pe_data_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [2:0]        res_slot;
    logic              res_last;

    pe_sequencer #(
        .DATA_W (DATA_W),
        .NUM_ACC(NUM_ACC),
        .LEN_W  (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_len        (job_len),
        .job_slots      (job_slots),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_a           (op_a),
        .op_b           (op_b),
        .pe_clr_n       (pe_clr_n),
        .pe_data_in_1   (pe_data_in_1),
        .pe_data_in_2   (pe_data_in_2),
        .pe_add_number  (pe_add_number),
        .pe_round_number(pe_round_number),
        .pe_rounder_en  (pe_rounder_en),
        .pe_data_out    (pe_data_out),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_slot       (res_slot),
        .res_last       (res_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Q7.9 round-half-up of a Q14.18 sum, saturated to 16 bits
    function automatic logic [15:0] q_round(input longint v);
        longint r;
        r = (v + 256) >>> 9;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    // Behavioural PE: multiplier register, 8 accumulators, registered rounder
    logic signed [31:0] pe_mult;
    logic signed [39:0] pe_acc [NUM_ACC];
    always @(posedge clk) begin
        if (!pe_clr_n) begin
            pe_mult     <= '0;
            pe_data_out <= '0;
            for (int i = 0; i < NUM_ACC; i++) pe_acc[i] <= '0;
        end else begin
            pe_mult <= $signed(pe_data_in_1) * $signed(pe_data_in_2);
            pe_acc[pe_add_number[2:0]] <= pe_acc[pe_add_number[2:0]] + 40'(pe_mult);
            if (pe_rounder_en) pe_data_out <= q_round(longint'(pe_acc[pe_round_number[2:0]]));
        end
    end

    // Reference: rounded sum of products over all steps of one slot
    function automatic logic [15:0] ref_result(input int s, input int steps);
        longint sum = 0;
        longint a;
        longint b;
        for (int k = 0; k < steps; k++) begin
            a = longint'($signed(qa[s*steps + k]));
            b = longint'($signed(qb[s*steps + k]));
            sum += a * b;
        end
        return q_round(sum);
    endfunction

    task automatic fill_grid(input int len, input int slots);
        qa.delete(); qb.delete();
        for (int s = 0; s <= slots; s++)
            for (int k = 0; k <= len; k++) begin
                qa.push_back(16'h0200);
                qb.push_back(16'(s * 16'h0200));
            end
    endtask

    task automatic fill_const(input int n, input logic [15:0] a, input logic [15:0] b);
        qa.delete(); qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_clr_n"}, pe_clr_n, 0);
        check_val({tag, "_din1"}, pe_data_in_1, 0);
        check_val({tag, "_din2"}, pe_data_in_2, 0);
        check_val({tag, "_add"}, pe_add_number, 0);
        check_val({tag, "_rnum"}, pe_round_number, 0);
        check_val({tag, "_ren"}, pe_rounder_en, 0);
        check_val({tag, "_rvalid"}, res_valid, 0);
        check_val({tag, "_rdata"}, res_data, 0);
        check_val({tag, "_rslot"}, res_slot, 0);
        check_val({tag, "_rlast"}, res_last, 0);
    endtask

    // op_mode: 0 full rate, 1 every other cycle, 2 random
    // rdy_mode: 0 always ready, 1 random, 2 ten-cycle stall on slot 2
    task automatic run_job(input int len, input int slots, input int op_mode,
                           input int rdy_mode, input bit hold_job, input bit chk_lat);
        int n_slots = slots + 1;
        int total   = (slots + 1) * (len + 1);
        int idx     = 0;
        int r       = 0;
        int stall   = 0;
        int guard;
        int t0;
        bit fire;
        bit first   = 1'b1;
        logic [15:0] ea;
        logic [15:0] eb;

        guard = 0;
        while (!job_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!job_ready) begin
            check_val("job_ready_timeout", 0, 1);
            return;
        end
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        job_slots = 3'(slots);
        t0 = cyc;
        @(negedge clk);
        if (!hold_job) job_valid = 1'b0;
        check_val("job_ready_busy", job_ready, 0);

        guard = 0;
        while (idx < total && guard < 5000) begin
            case (op_mode)
                0:       op_valid = 1'b1;
                1:       op_valid = cyc[0];
                default: op_valid = 1'($urandom_range(0, 1));
            endcase
            op_a = qa[idx];
            op_b = qb[idx];
            fire = op_valid && op_ready;
            ea   = fire ? op_a : 16'h0;
            eb   = fire ? op_b : 16'h0;
            @(negedge clk);
            guard++;
            check_val("pe_data_in_1", pe_data_in_1, ea);
            check_val("pe_data_in_2", pe_data_in_2, eb);
            if (fire) idx++;
        end
        op_valid = 1'b0;
        if (idx < total) begin
            check_val("feed_timeout", idx, total);
            return;
        end

        guard = 0;
        while (r < n_slots && guard < 5000) begin
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = !(r == 2 && stall < 10);
            endcase
            if (res_valid) begin
                if (first && chk_lat) check_val("res_latency", cyc - t0, total + 6);
                first = 1'b0;
                check_val("job_ready_in_out", job_ready, 0);
                check_val("res_data", res_data, ref_result(r, len + 1));
                check_val("res_slot", res_slot, r);
                check_val("res_last", res_last, (r == slots));
                if (!res_ready) begin
                    stall++;
                    check_val("rounder_en_stall", pe_rounder_en, 0);
                end else begin
                    r++;
                end
            end
            @(negedge clk);
            guard++;
        end
        res_ready = 1'b0;
        if (r < n_slots) begin
            check_val("result_timeout", r, n_slots);
            return;
        end
        check_val("job_ready_after", job_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_len   = '0;
        job_slots = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("job_ready_post_rst", job_ready, 1);

        // single op, single slot
        fill_const(1, 16'h0200, 16'h0300);
        run_job(0, 0, 0, 0, 1'b0, 1'b1);

        // full grid at full rate
        fill_grid(3, 7);
        run_job(3, 7, 0, 0, 1'b0, 1'b1);

        // full grid with operand bubbles
        fill_grid(3, 7);
        run_job(3, 7, 1, 0, 1'b0, 1'b0);

        // full grid with result backpressure on slot 2
        fill_grid(3, 7);
        run_job(3, 7, 0, 2, 1'b0, 1'b0);

        // reset during FEED of a saturating job
        while (!job_ready) @(negedge clk);
        job_valid = 1'b1;
        job_len   = 8'd7;
        job_slots = 3'd3;
        @(negedge clk);
        job_valid = 1'b0;
        op_valid  = 1'b1;
        op_a      = 16'h7FFF;
        op_b      = 16'h7FFF;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst1");
        @(negedge clk);
        check_reset_outputs("midrst2");
        rst_n    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check_val("job_ready_midrst", job_ready, 1);
        fill_const(1, 16'h0200, 16'h0200);
        run_job(0, 0, 0, 0, 1'b0, 1'b1);

        // back-to-back jobs with job_valid held high
        fill_const(4, 16'h0200, 16'h0200);
        run_job(1, 1, 0, 0, 1'b1, 1'b0);
        fill_const(4, 16'h0400, 16'h0200);
        run_job(1, 1, 0, 0, 1'b0, 1'b1);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            int len   = $urandom_range(0, 5);
            int slots = $urandom_range(0, 7);
            qa.delete(); qb.delete();
            for (int i = 0; i < (len + 1) * (slots + 1); i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    qa.push_back(16'($urandom_range(0, 65535)));
                    qb.push_back(16'($urandom_range(0, 65535)));
                end else begin
                    qa.push_back(16'(int'($urandom_range(0, 2048)) - 1024));
                    qb.push_back(16'(int'($urandom_range(0, 2048)) - 1024));
                end
            end
            run_job(len, slots, 2, 1, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
